// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - two-flop synchronizer + debounce FSM for a bouncing level input
// Optional FALL pulse output is built only when FALL_PULSE_EN is defined.

module input_conditioner #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input  logic CLK,
  input  logic RST,
  input  logic RAW,
  output logic CLEAN,
  output logic RISE
`ifdef FALL_PULSE_EN
  ,
  output logic FALL
`endif
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clean;
  logic             r_rise;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_clean_nxt;
  logic             w_rise_nxt;

`ifdef FALL_PULSE_EN
  logic r_fall;
  logic w_fall_nxt;
`endif

  // RAW is asynchronous; only r_sync2 is safe to decide on
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= RAW;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clean <= w_clean_nxt;
      r_rise  <= w_rise_nxt;
    end
  end

`ifdef FALL_PULSE_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fall <= 1'b0;
    end else begin
      r_fall <= w_fall_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clean_nxt = r_clean;
    w_rise_nxt  = 1'b0;
`ifdef FALL_PULSE_EN
    w_fall_nxt  = 1'b0;
`endif
    case (r_state)
      IDLE_LOW: begin
        w_clean_nxt = 1'b0;
        if (r_sync2) begin
          w_state_nxt = CHK_HIGH;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      CHK_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
          w_clean_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        w_clean_nxt = 1'b1;
        if (!r_sync2) begin
          w_state_nxt = CHK_LOW;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      CHK_LOW: begin
        if (r_sync2) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
          w_clean_nxt = 1'b0;
`ifdef FALL_PULSE_EN
          w_fall_nxt  = 1'b1;
`endif
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
        w_clean_nxt = 1'b0;
      end
    endcase
  end

  assign CLEAN = r_clean;
  assign RISE  = r_rise;
`ifdef FALL_PULSE_EN
  assign FALL  = r_fall;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed and randomized checks of input_conditioner (DB_CYCLES=4)
// FALL checks are compiled only when FALL_PULSE_EN is defined.

module tb_input_conditioner;

  localparam int DB = 4;

  logic CLK;
  logic rst;
  logic raw;
  logic CLEAN;
  logic RISE;
`ifdef FALL_PULSE_EN
  logic FALL;
  logic m_fall;
`endif

  int n_vec;
  int n_err;
  int cyc;

  // Reference: sync pipeline as two delayed copies of RAW; CLEAN flips once
  // DB consecutive synchronized samples disagree with it.
  logic m_s1, m_s2, m_clean, m_rise;
  int   m_run;

  input_conditioner #(.DB_CYCLES(DB), .CNT_W(5)) dut (
    .CLK  (CLK),
    .RST  (rst),
    .RAW  (raw),
    .CLEAN(CLEAN),
    .RISE (RISE)
`ifdef FALL_PULSE_EN
    ,
    .FALL (FALL)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_clean = 0; m_run = 0; m_rise = 0;
`ifdef FALL_PULSE_EN
      m_fall = 0;
`endif
    end else begin
      m_rise = 0;
`ifdef FALL_PULSE_EN
      m_fall = 0;
`endif
      if (m_s2 != m_clean) begin
        m_run++;
        if (m_run == DB) begin
          m_clean = ~m_clean;
          m_run = 0;
          if (m_clean) m_rise = 1;
`ifdef FALL_PULSE_EN
          else m_fall = 1;
`endif
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; raw = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (CLEAN !== 1'b0 || RISE !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: CLEAN=%b RISE=%b required 0 0", CLEAN, RISE);
      end
    end
    rst = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_vec++;
      if (CLEAN !== (k >= 6) || RISE !== (k == 6)) begin
        n_err++;
        $display("FAIL reset_release edge %0d: CLEAN=%b RISE=%b required %b %b",
                 k, CLEAN, RISE, k >= 6, k == 6);
      end
    end
  endtask

  task automatic test_glitch();
    rst = 1; raw = 0; tick(); rst = 0;
    for (int k = 0; k < 13; k++) begin
      raw = (k < 3);
      tick();
      n_vec++;
      if (CLEAN !== 1'b0 || RISE !== 1'b0
`ifdef FALL_PULSE_EN
          || FALL !== 1'b0
`endif
         ) begin
        n_err++;
        $display("FAIL short_pulse cycle %0d: CLEAN=%b RISE=%b required 0 0", k, CLEAN, RISE);
      end
    end
  endtask

  task automatic test_fall();
    raw = 1;
    repeat (8) tick();
    n_vec++;
    if (CLEAN !== 1'b1) begin
      n_err++;
      $display("FAIL fall_setup: CLEAN=%b required 1", CLEAN);
    end
    raw = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_vec++;
      if (CLEAN !== (k < 6)
`ifdef FALL_PULSE_EN
          || FALL !== (k == 6)
`endif
         ) begin
        n_err++;
        $display("FAIL fall edge %0d: CLEAN=%b required %b", k, CLEAN, k < 6);
      end
    end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 10; i++) begin
      raw = (i % 2 == 0);
      tick();
      n_vec++;
      if (CLEAN !== 1'b0 || RISE !== 1'b0) begin
        n_err++;
        $display("FAIL toggle cycle %0d: CLEAN=%b RISE=%b required 0 0", i, CLEAN, RISE);
      end
    end
    raw = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_vec++;
      if (CLEAN !== (k == 6) || RISE !== (k == 6)) begin
        n_err++;
        $display("FAIL toggle_settle edge %0d: CLEAN=%b RISE=%b required %b %b",
                 k, CLEAN, RISE, k == 6, k == 6);
      end
    end
  endtask

  task automatic test_rst_mid();
    rst = 1; raw = 1; tick(); rst = 0;
    repeat (4) tick();
    rst = 1; tick();
    n_vec++;
    if (CLEAN !== 1'b0 || RISE !== 1'b0
`ifdef FALL_PULSE_EN
        || FALL !== 1'b0
`endif
       ) begin
      n_err++;
      $display("FAIL rst_mid: CLEAN=%b RISE=%b required 0 0", CLEAN, RISE);
    end
    rst = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_vec++;
      if (CLEAN !== (k >= 6) || RISE !== (k == 6)) begin
        n_err++;
        $display("FAIL rst_mid_release edge %0d: CLEAN=%b RISE=%b required %b %b",
                 k, CLEAN, RISE, k >= 6, k == 6);
      end
    end
  endtask

  task automatic test_random();
    int last_chg;
    logic prev_clean;
    last_chg = cyc;
    prev_clean = CLEAN;
    while (cyc < 1200) begin
      int len;
      len = $urandom_range(1, 7);
      raw = 1'($urandom_range(0, 1));
      for (int j = 0; j < len; j++) begin
        rst = ($urandom_range(0, 60) == 0);
        tick();
        n_vec++;
        if (CLEAN !== m_clean || RISE !== m_rise
`ifdef FALL_PULSE_EN
            || FALL !== m_fall
`endif
           ) begin
          n_err++;
          $display("FAIL random cyc %0d: CLEAN=%b RISE=%b required %b %b",
                   cyc, CLEAN, RISE, m_clean, m_rise);
        end
        if (rst) begin
          last_chg = cyc;
        end else if (CLEAN !== prev_clean) begin
          n_vec++;
          if (cyc - last_chg < DB) begin
            n_err++;
            $display("FAIL toggle_spacing cyc %0d: gap=%0d required >=%0d",
                     cyc, cyc - last_chg, DB);
          end
          last_chg = cyc;
        end
        prev_clean = CLEAN;
      end
    end
    rst = 0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    rst = 1; raw = 0;
    m_s1 = 0; m_s2 = 0; m_clean = 0; m_rise = 0; m_run = 0;
`ifdef FALL_PULSE_EN
    m_fall = 0;
`endif
    test_reset();
    test_glitch();
    test_fall();
    test_toggle();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
